// File: rtl/out_ctl_if.sv
// Result stream interface for out_ctl: valid/ready beats with data and
// end-of-block marker.
interface out_ctl_if #(
    parameter int DW = 32
);
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/out_ctl.sv
// Output controller: captures a finished kernel and streams N result words.
// Optional error flag enabled by macro OUTCTL_ERR_EN.
module out_ctl #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_init,
    input  logic          k_fin,
    output logic          out_busy,
    output logic          outrf,
    output logic          cap,
    output logic          ren,
    output logic [AW-1:0] oa,
    input  logic [DW-1:0] rd_data,
    out_ctl_if.master     m,
    output logic          err
);
    localparam int N = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAP,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW:0]   r_rcnt;
    logic [AW-1:0] r_bcnt;
    logic          r_inflight;
    logic          r_outrf;
    logic [DW-1:0] r_fifo [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_cnt;
    logic          w_pop;
    logic          w_push;
    logic          w_done;
    logic [2:0]    w_lvl;

    assign w_pop  = m.m_valid && m.m_ready;
    assign w_push = r_inflight;
    assign w_done = w_pop && (r_bcnt == AW'(N - 1));
    // Words buffered or in flight after this cycle's pop
    assign w_lvl  = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (k_fin) w_next = S_CAP;
            S_CAP:   w_next = S_DRAIN;
            S_DRAIN: if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cap      = 1'b0;
        out_busy = 1'b0;
        ren      = 1'b0;
        unique case (r_state)
            S_CAP: begin
                cap      = 1'b1;
                out_busy = 1'b1;
            end
            S_DRAIN: begin
                out_busy = 1'b1;
                ren      = !r_rcnt[AW] && (w_lvl < 3'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt     <= '0;
            r_bcnt     <= '0;
            r_inflight <= 1'b0;
            r_outrf    <= 1'b0;
        end else begin
            if (cap)        r_rcnt <= '0;
            else if (ren)   r_rcnt <= r_rcnt + 1'b1;
            if (w_pop)      r_bcnt <= r_bcnt + 1'b1;
            r_inflight <= ren;
            r_outrf    <= w_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= rd_data;
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign oa       = r_rcnt[AW-1:0];
    assign outrf    = r_outrf;
    assign m.m_valid = (r_cnt != 2'd0);
    assign m.m_data  = r_fifo[r_rp];
    assign m.m_last  = m.m_valid && (r_bcnt == AW'(N - 1));

`ifdef OUTCTL_ERR_EN
    logic r_err;

    // A set in the same cycle as s_init wins over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_err <= 1'b0;
        else if (k_fin && out_busy)     r_err <= 1'b1;
        else if (s_init)                r_err <= 1'b0;
    end

    assign err = r_err;
`else
    logic w_unused_sinit;
    assign w_unused_sinit = s_init;
    assign err = 1'b0;
`endif
endmodule
